// File: rtl/psum_gbf_pkg.sv
// Shared types, sizes and helpers for the double-buffered psum global buffer.
// Holds the lane-wise add used by the RMW pipeline and the drain state encoding.
package psum_gbf_pkg;

  localparam int DATA_BITWIDTH     = 16;
  localparam int GBF_DATA_BITWIDTH = 512;
  localparam int LANES             = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int DEPTH             = 32;
  localparam int ADDR_BITWIDTH     = $clog2(DEPTH);
  localparam int CFG_BITWIDTH      = ADDR_BITWIDTH + 1;

  typedef logic [GBF_DATA_BITWIDTH-1:0] line_t;
  typedef logic [ADDR_BITWIDTH-1:0]     addr_t;
  typedef logic [CFG_BITWIDTH-1:0]      cfg_t;

  typedef enum logic [1:0] {
    DRN_IDLE,
    DRN_WAIT2,
    DRN_RD,
    DRN_VALID
  } drain_state_e;

  // Per-lane two's-complement add, wrapping mod 2^16; init selects overwrite.
  function automatic line_t lane_add(input line_t old_line, input line_t new_line,
                                     input logic init);
    line_t sum;
    for (int i = 0; i < LANES; i++) begin
      sum[i*DATA_BITWIDTH +: DATA_BITWIDTH] = init ?
          new_line[i*DATA_BITWIDTH +: DATA_BITWIDTH] :
          old_line[i*DATA_BITWIDTH +: DATA_BITWIDTH] + new_line[i*DATA_BITWIDTH +: DATA_BITWIDTH];
    end
    return sum;
  endfunction

  // Index of the final drained line; 0 (and anything beyond DEPTH) means a full bank.
  function automatic addr_t last_line(input cfg_t cfg);
    if (cfg == '0 || cfg > cfg_t'(DEPTH)) return addr_t'(DEPTH - 1);
    return addr_t'(cfg - 1'b1);
  endfunction

endpackage

// File: rtl/psum_gbf_if.sv
// Write-beat and drain-stream bundle between the psum accumulator, the buffer
// and the downstream consumer. master = upstream/downstream side, slave = buffer.
interface psum_gbf_if;
  import psum_gbf_pkg::*;

  logic  w_en;
  addr_t w_addr;
  line_t w_data;
  logic  w_bank;
  logic  w_init;

  logic  rd_valid;
  logic  rd_ready;
  line_t rd_data;
  addr_t rd_addr;
  logic  rd_last;

  modport master (
    output w_en, w_addr, w_data, w_bank, w_init, rd_ready,
    input  rd_valid, rd_data, rd_addr, rd_last
  );

  modport slave (
    input  w_en, w_addr, w_data, w_bank, w_init, rd_ready,
    output rd_valid, rd_data, rd_addr, rd_last
  );

endinterface

// File: rtl/psum_gbf_ram.sv
// 2*DEPTH x 512 line store addressed {bank, line}. Port A serves the RMW
// pipeline (read at S0, write at S1); port B serves the drain read.
module psum_gbf_ram
  import psum_gbf_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_rd_en,
  input  logic [ADDR_BITWIDTH:0] a_rd_addr,
  output line_t                  a_rd_data,
  input  logic                   a_wr_en,
  input  logic [ADDR_BITWIDTH:0] a_wr_addr,
  input  line_t                  a_wr_data,
  input  logic                   b_rd_en,
  input  logic [ADDR_BITWIDTH:0] b_rd_addr,
  output line_t                  b_rd_data
);

  line_t mem [2*DEPTH];
  line_t a_rd_data_q, a_rd_data_d;
  line_t b_rd_data_q, b_rd_data_d;

  // NOTE: the array itself is never reset so it maps onto a plain SRAM macro;
  // only the read-data registers reset, which keeps rd_data at 0 after reset.
  always_ff @(posedge clk) begin
    if (a_wr_en) mem[a_wr_addr] <= a_wr_data;
  end

  // Same-edge read of a line being written returns the old value; the top forwards.
  always_comb begin
    a_rd_data_d = a_rd_en ? mem[a_rd_addr] : a_rd_data_q;
    b_rd_data_d = b_rd_en ? mem[b_rd_addr] : b_rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_data_q <= '0;
      b_rd_data_q <= '0;
    end else begin
      a_rd_data_q <= a_rd_data_d;
      b_rd_data_q <= b_rd_data_d;
    end
  end

  assign a_rd_data = a_rd_data_q;
  assign b_rd_data = b_rd_data_q;

endmodule

// File: rtl/psum_gbf_bank.sv
// Double-buffered psum global buffer: a 2-stage read-modify-write pipeline
// accumulates into one bank while a valid/ready drain empties the other.
module psum_gbf_bank
  import psum_gbf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  cfg_t       cfg_lines,
  psum_gbf_if.slave  bus,
  output logic       drain_busy,
  output logic       err_collide
);

  logic  s1_valid_q, s1_valid_d;
  logic  s1_fwd_q,   s1_fwd_d;
  logic  s1_bank_q,  s1_bank_d;
  addr_t s1_addr_q,  s1_addr_d;
  line_t s1_data_q,  s1_data_d;
  logic  s1_init_q,  s1_init_d;
  line_t fwd_data_q, fwd_data_d;
  line_t a_rd_data, b_rd_data, old_line, s1_sum;
  logic  fwd_hit;

  drain_state_e state_q, state_d;
  logic  bank_q,       bank_d;
  logic  drain_bank_q, drain_bank_d;
  logic  wait_q,       wait_d;
  addr_t rd_ptr_q,     rd_ptr_d;
  addr_t last_q,       last_d;
  addr_t rd_addr_q,    rd_addr_d;
  logic  rd_valid_q,   rd_valid_d;
  logic  rd_last_q,    rd_last_d;
  logic  busy_q,       busy_d;
  logic  err_q,        err_d;
  logic  toggle;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    fwd_hit    = bus.w_en && s1_valid_q && (bus.w_bank == s1_bank_q) &&
                 (bus.w_addr == s1_addr_q);
    old_line   = s1_fwd_q ? fwd_data_q : a_rd_data;
    s1_sum     = lane_add(old_line, s1_data_q, s1_init_q);
    s1_valid_d = bus.w_en;
    s1_fwd_d   = fwd_hit;
    s1_bank_d  = bus.w_en ? bus.w_bank : s1_bank_q;
    s1_addr_d  = bus.w_en ? bus.w_addr : s1_addr_q;
    s1_data_d  = bus.w_en ? bus.w_data : s1_data_q;
    s1_init_d  = bus.w_en ? bus.w_init : s1_init_q;
    fwd_data_d = fwd_hit ? s1_sum : fwd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_fwd_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fwd_q   <= s1_fwd_d;
    end
  end

  // Datapath registers are qualified by s1_valid_q/s1_fwd_q and need no reset.
  always_ff @(posedge clk) begin
    s1_bank_q  <= s1_bank_d;
    s1_addr_q  <= s1_addr_d;
    s1_data_q  <= s1_data_d;
    s1_init_q  <= s1_init_d;
    fwd_data_q <= fwd_data_d;
  end

  psum_gbf_ram u_ram (
    .clk       (clk),
    .reset     (reset),
    .a_rd_en   (bus.w_en),
    .a_rd_addr ({bus.w_bank, bus.w_addr}),
    .a_rd_data (a_rd_data),
    .a_wr_en   (s1_valid_q),
    .a_wr_addr ({s1_bank_q, s1_addr_q}),
    .a_wr_data (s1_sum),
    .b_rd_en   (state_q == DRN_RD),
    .b_rd_addr ({drain_bank_q, rd_ptr_q}),
    .b_rd_data (b_rd_data)
  );

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    drain_bank_d = drain_bank_q;
    wait_d       = wait_q;
    rd_ptr_d     = rd_ptr_q;
    last_d       = last_q;
    rd_addr_d    = rd_addr_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    err_d        = err_q;
    toggle       = (bus.w_bank != bank_q);

    if (state_q != DRN_IDLE) begin
      if (toggle) err_d = 1'b1;
      if (bus.w_en && (bus.w_bank == drain_bank_q)) err_d = 1'b1;
    end

    unique case (state_q)
      DRN_IDLE: begin
        if (toggle) begin
          state_d      = DRN_WAIT2;
          drain_bank_d = bank_q;
          bank_d       = bus.w_bank;
          wait_d       = 1'b0;
          rd_ptr_d     = '0;
          last_d       = last_line(cfg_lines);
        end
      end
      // Two idle cycles let the final S1 write of the completed bank retire.
      DRN_WAIT2: begin
        wait_d = 1'b1;
        if (wait_q) state_d = DRN_RD;
      end
      DRN_RD: begin
        state_d    = DRN_VALID;
        rd_valid_d = 1'b1;
        rd_addr_d  = rd_ptr_q;
        rd_last_d  = (rd_ptr_q == last_q);
      end
      DRN_VALID: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            state_d = DRN_IDLE;
          end else begin
            rd_ptr_d = addr_t'(rd_ptr_q + 1'b1);
            state_d  = DRN_RD;
          end
        end
      end
      default: state_d = DRN_IDLE;
    endcase

    busy_d = (state_d != DRN_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= DRN_IDLE;
      bank_q       <= 1'b0;
      drain_bank_q <= 1'b0;
      wait_q       <= 1'b0;
      rd_ptr_q     <= '0;
      last_q       <= '0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      drain_bank_q <= drain_bank_d;
      wait_q       <= wait_d;
      rd_ptr_q     <= rd_ptr_d;
      last_q       <= last_d;
      rd_addr_q    <= rd_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = b_rd_data;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_last  = rd_last_q;
  assign drain_busy   = busy_q;
  assign err_collide  = err_q;

endmodule

// File: tb/tb_psum_gbf_bank.sv
// Randomized bench for psum_gbf_bank against a lane-array model of both banks;
// drained lines are compared with snapshots taken when each bank is switched out.
module tb_psum_gbf_bank;
  import psum_gbf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  cfg_t cfg_lines;
  logic drain_busy, err_collide;

  psum_gbf_if dbus ();

  psum_gbf_bank dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_lines   (cfg_lines),
    .bus         (dbus),
    .drain_busy  (drain_busy),
    .err_collide (err_collide)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [DATA_BITWIDTH-1:0] mdl [2][DEPTH][LANES];

  typedef struct {
    line_t data;
    int    addr;
    bit    last;
  } exp_t;

  exp_t  exp_q[$];
  line_t got_line [DEPTH];
  logic  cur_bank;
  int    dn;

  function automatic line_t model_line(input logic b, input int a);
    line_t l;
    for (int i = 0; i < LANES; i++) l[i*DATA_BITWIDTH +: DATA_BITWIDTH] = mdl[b][a][i];
    return l;
  endfunction

  function automatic line_t splat(input logic [DATA_BITWIDTH-1:0] v);
    line_t l;
    for (int i = 0; i < LANES; i++) l[i*DATA_BITWIDTH +: DATA_BITWIDTH] = v;
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < GBF_DATA_BITWIDTH/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One beat, presented for exactly one cycle; the model absorbs it immediately.
  task automatic do_write(input logic b, input int a, input line_t d, input bit init);
    dbus.w_en   = 1'b1;
    dbus.w_bank = b;
    dbus.w_addr = addr_t'(a);
    dbus.w_data = d;
    dbus.w_init = init;
    for (int i = 0; i < LANES; i++)
      mdl[b][a][i] = init ? d[i*DATA_BITWIDTH +: DATA_BITWIDTH]
                          : mdl[b][a][i] + d[i*DATA_BITWIDTH +: DATA_BITWIDTH];
    @(posedge clk); #1;
    dbus.w_en   = 1'b0;
    dbus.w_bank = cur_bank;
  endtask

  task automatic init_pass(input logic b);
    for (int a = 0; a < DEPTH; a++) begin
      do_write(b, a, rand_line(), 1'b1);
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic start_switch(input int cfg);
    int eff;
    eff = (cfg == 0 || cfg > DEPTH) ? DEPTH : cfg;
    for (int a = 0; a < eff; a++)
      exp_q.push_back('{model_line(cur_bank, a), a, (a == eff - 1)});
    cfg_lines   = cfg_t'(cfg);
    cur_bank    = ~cur_bank;
    dbus.w_bank = cur_bank;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low 5 cycles on the first line.
  task automatic run_drain(input int mode, input int abort_at, output int n);
    int waited, hold, total, extra;
    bit rdy;
    waited = 0;
    hold   = 0;
    n      = 0;
    total  = exp_q.size();
    while (exp_q.size() > 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
      if (dbus.rd_valid) begin
        check("rd_addr", dbus.rd_addr, exp_q[0].addr);
        if (n == abort_at) break;
        check("rd_data", dbus.rd_data, exp_q[0].data);
        check("rd_last", dbus.rd_last, exp_q[0].last);
        if (mode == 2 && hold < 5) begin
          rdy = 1'b0;
          hold++;
        end else if (mode == 1) begin
          rdy = bit'($urandom_range(1));
        end else begin
          rdy = 1'b1;
        end
        dbus.rd_ready = rdy;
        if (rdy) begin
          got_line[exp_q[0].addr] = dbus.rd_data;
          void'(exp_q.pop_front());
          n++;
        end
      end else begin
        dbus.rd_ready = logic'($urandom_range(1));
      end
    end
    if (abort_at < 0) begin
      check("drain_lines", n, total);
      exp_q.delete();
      @(negedge clk);
      dbus.rd_ready = 1'b0;
      check("busy_after_drain", drain_busy, 1'b0);
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (dbus.rd_valid) extra++;
      end
      check("no_extra_lines", extra, 0);
    end
  endtask

  task automatic random_accumulate(input int beats);
    int a, last_a;
    last_a = 0;
    repeat (beats) begin
      a = ($urandom_range(2) == 0) ? last_a : int'($urandom_range(DEPTH - 1));
      do_write(cur_bank, a, rand_line(), ($urandom_range(7) == 0));
      last_a = a;
      if ($urandom_range(4) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    cfg_lines     = cfg_t'(DEPTH);
    cur_bank      = 1'b0;
    dbus.w_en     = 1'b0;
    dbus.w_bank   = 1'b0;
    dbus.w_addr   = '0;
    dbus.w_data   = '0;
    dbus.w_init   = 1'b0;
    dbus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_valid", dbus.rd_valid, 1'b0);
    check("rst_rd_data", dbus.rd_data, '0);
    check("rst_rd_addr", dbus.rd_addr, '0);
    check("rst_rd_last", dbus.rd_last, 1'b0);
    check("rst_busy", drain_busy, 1'b0);
    check("rst_err", err_collide, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single pass into bank 0, lanes = addr, full-bank drain.
    for (int a = 0; a < DEPTH; a++) do_write(1'b0, a, splat(16'(a)), 1'b1);
    start_switch(DEPTH);
    run_drain(0, -1, dn);
    check("single_pass_lines", dn, DEPTH);
    check("single_pass_line31", got_line[31], splat(16'd31));

    // Accumulation, wrap and back-to-back forwarding into bank 1.
    for (int a = 0; a < 8; a++) do_write(cur_bank, a, rand_line(), 1'b1);
    do_write(cur_bank, 5, splat(16'd1), 1'b1);
    do_write(cur_bank, 5, splat(16'd2), 1'b0);
    do_write(cur_bank, 5, splat(16'd3), 1'b0);
    do_write(cur_bank, 6, splat(16'h7FFF), 1'b1);
    do_write(cur_bank, 6, splat(16'd1), 1'b0);
    do_write(cur_bank, 7, splat(16'd0), 1'b1);
    do_write(cur_bank, 7, splat(16'd1), 1'b0);
    do_write(cur_bank, 7, splat(16'd1), 1'b0);
    do_write(cur_bank, 7, splat(16'd1), 1'b0);
    start_switch(8);
    run_drain(1, -1, dn);
    check("accum_3_pass", got_line[5], splat(16'd6));
    check("accum_wrap", got_line[6], splat(16'h8000));
    check("b2b_forward", got_line[7], splat(16'd3));

    // Backpressure with a 4-line drain while the other bank fills.
    start_switch(4);
    fork
      run_drain(2, -1, dn);
      init_pass(cur_bank);
    join
    check("backpressure_lines", dn, 4);
    check("err_clean", err_collide, 1'b0);

    // Random rounds: accumulate, switch with random length, fill the new bank.
    for (int r = 0; r < 5; r++) begin
      random_accumulate(40);
      start_switch(int'($urandom_range(DEPTH)));
      fork
        run_drain(1, -1, dn);
        init_pass(cur_bank);
      join
    end
    check("err_clean_random", err_collide, 1'b0);

    // Toggle during a drain: flagged, ignored, drain still completes.
    random_accumulate(20);
    start_switch(16);
    fork
      run_drain(1, -1, dn);
      begin
        repeat (6) @(posedge clk);
        #1 dbus.w_bank = ~cur_bank;
        repeat (3) @(posedge clk);
        #1 dbus.w_bank = cur_bank;
      end
    join
    check("toggle_collide_err", err_collide, 1'b1);
    check("toggle_collide_lines", dn, 16);

    // Reset at line 10 of a full drain.
    start_switch(DEPTH);
    run_drain(1, 10, dn);
    check("abort_point", dn, 10);
    #2;
    reset         = 1'b1;
    cur_bank      = 1'b0;
    dbus.w_bank   = 1'b0;
    dbus.rd_ready = 1'b0;
    #1;
    check("async_rst_rd_valid", dbus.rd_valid, 1'b0);
    check("async_rst_busy", drain_busy, 1'b0);
    check("async_rst_err", err_collide, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Post-reset drain restarts at address 0; a write to the draining bank is flagged.
    for (int a = 0; a < 4; a++) do_write(1'b0, a, rand_line(), 1'b1);
    start_switch(4);
    fork
      run_drain(1, -1, dn);
      begin
        repeat (3) @(posedge clk);
        #1;
        do_write(1'b0, 20, rand_line(), 1'b1);
      end
    join
    check("post_reset_lines", dn, 4);
    check("write_collide_err", err_collide, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
